nonce_scan_ctrl: RTL
====================

# nonce_scan_ctrl

Sequences one Sha256Ppl instance through a nonce scan. Accepts a job (initial hash state, 512-bit chunk template, nonce range, target) and issues one chunk per cycle with the nonce word substituted. Matches in-order pipeline results back to their nonces, filters them against the target, and queues hits for the host interface. Sits between the job/config register block and the hash pipeline.

## Interface
- NONCE_IDX, 3: chunk word index (0..15) replaced by the nonce; word 0 is chunk[511:480].
- PPL_LAT, 66: cycles from `ppl_valid_o` to the matching `ppl_valid_i`.
- RES_DEPTH, 4: result FIFO depth, power of two.
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- job_valid_i  in  1  job offered.
- job_ready_o  out  1  ready to accept a job; high only in IDLE.
- job_init_i  in  256  initial hash words; init_0 in [255:224].
- job_chunk_i  in  512  chunk template; chunk_0 in [511:480].
- job_nonce_start_i / job_nonce_end_i  in  32 each  inclusive nonce range.
- job_target_i  in  32  hit threshold.
- abort_i  in  1  abandon the current job.
- ppl_valid_o  out  1  drives the pipeline's valid_i.
- ppl_init_o  out  256  drives init_0..7.
- ppl_chunk_o  out  512  drives chunk_0..15.
- ppl_valid_i  in  1  pipeline valid_o.
- ppl_hash_i  in  256  {hash_0..hash_7}.
- res_valid_o / res_ready_i  out / in  1 each  result handshake.
- res_nonce_o  out  32  winning nonce.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the job has fully drained.
- aborted_o  out  1  qualifies `done_o`: the job was aborted.
- drop_cnt_o  out  8  saturating count of hits lost to a full FIFO; cleared on job accept.

## Operation
- States are IDLE, SCAN and DRAIN.
- IDLE: `job_ready_o`=1. On `job_valid_i`:
  - Latch init, chunk, start, end and target.
  - Set issue nonce = start and `res_cnt` = 0.
  - Clear `drop_cnt_o` and the abort flag.
  - Go to SCAN.
- SCAN:
  - `ppl_valid_o`=1 every cycle.
  - `ppl_chunk_o` is the template with word NONCE_IDX = issue nonce.
  - Issue nonce increments by 1 modulo 2^32.
  - After issuing nonce == end, go to DRAIN. The range may wrap through 0xFFFFFFFF→0. start == end issues exactly one nonce.
- abort_i in SCAN: no issue that cycle; set the abort flag; go to DRAIN.
- abort_i in IDLE or DRAIN: ignored.
- DRAIN:
  - No issue.
  - Wait until `in_flight` == 0, then pulse `done_o` (with `aborted_o` = flag) and go to IDLE.
- `in_flight` counter, 0..PPL_LAT+1: +1 per issue, −1 per `ppl_valid_i`. Both in one cycle leave it unchanged.
- `ppl_init_o` holds the latched init from accept until the return to IDLE. The pipeline reads init again at its output stage.
- Result matching:
  - Each `ppl_valid_i` gives result nonce = start + `res_cnt`; then `res_cnt`++. The pipeline is in order and lossless.
  - hit = `ppl_valid_i` && hash_7 == 0 && hash_6 <= target (unsigned) && !abort flag.
  - A hit with the FIFO full is discarded and `drop_cnt_o`++ (saturates at 255).
  - A hit when the FIFO is full and `res_ready_i` pops in the same cycle is accepted.
- FIFO contents survive job end and new job accept; only arst clears them.
- Reset values: state IDLE; `job_ready_o` 1; `ppl_valid_o`, `res_valid_o`, `busy_o`, `done_o`, `aborted_o` 0; `drop_cnt_o` 0; all data outputs 0; FIFO empty.

## Timing
- Accept at cycle T. Nonce start+k is issued at T+1+k; N = end−start+1 (mod 2^32) nonces are issued in T+1..T+N.
- Last result arrives at T+N+PPL_LAT. `done_o` is at T+N+PPL_LAT+1, with `job_ready_o` high that same cycle.
- Hit registered into the FIFO: `res_valid_o` one cycle after `ppl_valid_i`.
- Abort at cycle A, no accept in between: `done_o` at (last issue)+PPL_LAT+1; no results from the aborted job are queued.
- New job is accepted earliest in the cycle `done_o` is high.
- Full-range scan (end == start−1) issues 2^32 nonces.

## Structure
- Package `miner_pkg`:
  - State enum.
  - `PPL_LAT_DEFAULT` = 66.
  - Hit-compare function.
- Sub-module `res_fifo`: sync FIFO, width 32, depth RES_DEPTH, with push/pop/full/empty; first-word output registered.

## Test plan
- Range 0x10..0x13, target 0xFFFFFFFF, model returns hash_7=0 for all: 4 issues at T+1..T+4; results 0x10,0x11,0x12,0x13 in order; `done_o` at T+4+66+1.
- Wrap range 0xFFFFFFFE..0x00000001: issued nonces are FFFFFFFE, FFFFFFFF, 0, 1 in word 3; `ppl_init_o` is stable until `done_o`.
- Hits at result indices 0..5 with `res_ready_i`=0 and RES_DEPTH 4: 4 queued, `drop_cnt_o`=2; popping yields start..start+3.
- Target compare: hash_6 = target passes; hash_6 = target+1 fails; hash_7 = 1 fails.
- Abort after 10 issues: no further `ppl_valid_o`; no results queued; `done_o` with `aborted_o`=1 at (last issue)+67; a new job is accepted that cycle.
- arst asserted mid-SCAN with 20 in flight: all outputs are at reset values immediately; late `ppl_valid_i` pulses are ignored with no results and no `in_flight` underflow.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce scan controller and its result queue.
package miner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    localparam int PPL_LAT_DEFAULT = 66;

    // Hash words are compared as a 64-bit little-end value: top word must be zero.
    function automatic logic is_hit(input logic [31:0] hash_7,
                                    input logic [31:0] hash_6,
                                    input logic [31:0] target);
        return (hash_7 == 32'd0) && (hash_6 <= target);
    endfunction

endpackage

// File: rtl/nonce_scan_ctrl_res_fifo.sv
// Synchronous result FIFO with a registered head word; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module res_fifo
    import miner_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full_o   = (cnt_q == (AW+1)'(DEPTH));
        empty_o  = (cnt_q == '0);
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din_i;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        // Pre-load the word that will be at the head after this cycle.
        if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din_i;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/nonce_scan_ctrl.sv
// Drives one hash pipeline through a nonce range and queues nonces whose
// in-order results meet the job target.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a job, job_ready_o high
// ST_SCAN  | issuing one chunk per cycle with the nonce substituted
// ST_DRAIN | no issue; waiting for all in-flight results to return
module nonce_scan_ctrl
    import miner_pkg::*;
#(
    parameter int NONCE_IDX = 3,
    parameter int PPL_LAT   = PPL_LAT_DEFAULT,
    parameter int RES_DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         job_valid_i,
    output logic         job_ready_o,
    input  logic [255:0] job_init_i,
    input  logic [511:0] job_chunk_i,
    input  logic [31:0]  job_nonce_start_i,
    input  logic [31:0]  job_nonce_end_i,
    input  logic [31:0]  job_target_i,
    input  logic         abort_i,
    output logic         ppl_valid_o,
    output logic [255:0] ppl_init_o,
    output logic [511:0] ppl_chunk_o,
    input  logic         ppl_valid_i,
    input  logic [255:0] ppl_hash_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [31:0]  res_nonce_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         aborted_o,
    output logic [7:0]   drop_cnt_o
);

    localparam int IF_W     = $clog2(PPL_LAT + 2);
    localparam int WORD_LSB = 32 * (15 - NONCE_IDX);

    scan_state_e  state_q, state_d;
    logic [255:0] init_q, init_d;
    logic [511:0] chunk_q, chunk_d;
    logic [31:0]  nonce_q, nonce_d;
    logic [31:0]  start_q, start_d;
    logic [31:0]  end_q, end_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  res_cnt_q, res_cnt_d;
    logic         abort_q, abort_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;
    logic [IF_W-1:0] in_flight_q, in_flight_d;
    logic         done_q, done_d;
    logic         aborted_q, aborted_d;

    logic         issue;
    logic         ret;
    logic         hit;
    logic [31:0]  res_nonce;
    logic         fifo_full;
    logic         fifo_empty;

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        chunk_d     = chunk_q;
        nonce_d     = nonce_q;
        start_d     = start_q;
        end_d       = end_q;
        target_d    = target_q;
        res_cnt_d   = res_cnt_q;
        abort_d     = abort_q;
        drop_cnt_d  = drop_cnt_q;
        in_flight_d = in_flight_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        issue       = 1'b0;

        // Returns with nothing outstanding (e.g. stale beats after reset) are dropped.
        ret       = ppl_valid_i && (in_flight_q != '0);
        res_nonce = start_q + res_cnt_q;
        hit       = ret && !abort_q && is_hit(ppl_hash_i[31:0], ppl_hash_i[63:32], target_q);
        if (ret) begin
            res_cnt_d = res_cnt_q + 32'd1;
        end
        if (hit && fifo_full && !res_ready_i && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (job_valid_i) begin
                    init_d     = job_init_i;
                    chunk_d    = job_chunk_i;
                    start_d    = job_nonce_start_i;
                    end_d      = job_nonce_end_i;
                    target_d   = job_target_i;
                    nonce_d    = job_nonce_start_i;
                    res_cnt_d  = 32'd0;
                    drop_cnt_d = 8'd0;
                    abort_d    = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    issue   = 1'b1;
                    nonce_d = nonce_q + 32'd1;
                    if (nonce_q == end_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({issue, ret})
            2'b10:   in_flight_d = in_flight_q + IF_W'(1);
            2'b01:   in_flight_d = in_flight_q - IF_W'(1);
            default: in_flight_d = in_flight_q;
        endcase

        // done_o is registered so it lands in the first IDLE cycle.
        if ((state_q == ST_DRAIN) && (in_flight_d == '0)) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aborted_d = abort_q;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            init_q      <= '0;
            chunk_q     <= '0;
            nonce_q     <= '0;
            start_q     <= '0;
            end_q       <= '0;
            target_q    <= '0;
            res_cnt_q   <= '0;
            abort_q     <= 1'b0;
            drop_cnt_q  <= '0;
            in_flight_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            chunk_q     <= chunk_d;
            nonce_q     <= nonce_d;
            start_q     <= start_d;
            end_q       <= end_d;
            target_q    <= target_d;
            res_cnt_q   <= res_cnt_d;
            abort_q     <= abort_d;
            drop_cnt_q  <= drop_cnt_d;
            in_flight_q <= in_flight_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        ppl_chunk_o = chunk_q;
        ppl_chunk_o[WORD_LSB +: 32] = nonce_q;
    end

    res_fifo #(
        .WIDTH (32),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .arst    (arst),
        .push_i  (hit),
        .din_i   (res_nonce),
        .pop_i   (res_ready_i),
        .dout_o  (res_nonce_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign job_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign ppl_valid_o = issue;
    assign ppl_init_o  = init_q;
    assign res_valid_o = !fifo_empty;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
